truth_table_checker: RTL

Synthesizable self-test engine that replaces a simulation-only stimulus bench on the board. It walks every input combination of a small combinational DUT (default: the 3-input `sillyfunction`), samples the DUT output after a settle window, and compares it against a parameterised expected truth table. It reports pass/fail, a mismatch count and the first failing vector to LEDs/debug logic. It sits between the board clock/reset/button logic and the DUT's `a`, `b`, `c`, `y` pins.

---
 rtl/tt_check_pkg.sv | 15 +
 rtl/sync_2ff.sv | 28 ++
 rtl/truth_table_checker.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tt_check_pkg.sv
// tt_check_pkg: shared types and constants for the truth-table self-test engine.
//   tt_state_e      - sweep FSM state encoding (2 bits)
//   SILLY_EXPECTED  - truth table of sillyfunction, y = ~b&~c | a&~b, indexed by {a,b,c}
package tt_check_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StApply  = 2'd1,
        StSample = 2'd2,
        StFinish = 2'd3
    } tt_state_e;

    localparam logic [7:0] SILLY_EXPECTED = 8'h31;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer for an asynchronous input.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset, clears both flops
//   d_in   in  asynchronous input
//   q_out  out synchronized output, two clock cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic q_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input vector of a small combinational DUT, waits a settle
// window, samples the DUT output and compares it with an expected truth table.
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   start            in   single-cycle sweep request, ignored while busy
//   stim_out         out  registered stimulus {a,b,c}
//   y_in             in   DUT response, asynchronous
//   busy             out  sweep in progress
//   done             out  one-cycle pulse at sweep completion
//   pass             out  last sweep had zero mismatches
//   err_count        out  mismatching vectors in last sweep
//   first_err_valid  out  at least one mismatch seen
//   first_err_idx    out  stimulus value of the first mismatch
module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int unsigned               N_IN     = 3,
    parameter logic [(1 << N_IN) - 1:0]  EXPECTED = SILLY_EXPECTED,
    parameter int unsigned               SETTLE   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] stim_out,
    input  logic            y_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_err_valid,
    output logic [N_IN-1:0] first_err_idx
);

    localparam int unsigned ERR_W = N_IN + 1;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    tt_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  stim_q, stim_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             first_valid_q, first_valid_d;
    logic [N_IN-1:0]  first_idx_q, first_idx_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic y_sync;
    logic mismatch;

    sync_2ff u_sync_y (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (y_in),
        .q_out (y_sync)
    );

    assign mismatch = (y_sync != EXPECTED[stim_q]);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stim_d        = stim_q;
        err_d         = err_q;
        first_valid_d = first_valid_q;
        first_idx_d   = first_idx_q;
        pass_d        = pass_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d       = StApply;
                    cnt_d         = '0;
                    stim_d        = '0;
                    err_d         = '0;
                    first_valid_d = 1'b0;
                    first_idx_d   = '0;
                    pass_d        = 1'b0;
                    busy_d        = 1'b1;
                end
            end

            // The entry cycle plus SETTLE-1 counted cycles give the synchronizer time to
            // present the response to the current vector before SAMPLE.
            StApply: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = StSample;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StSample: begin
                if (mismatch) begin
                    err_d = err_q + ERR_W'(1);
                    if (!first_valid_q) begin
                        first_valid_d = 1'b1;
                        first_idx_d   = stim_q;
                    end
                end
                if (stim_q == LAST_VEC) begin
                    // Stimulus stays on the all-ones vector; no wrap.
                    state_d = StFinish;
                end else begin
                    stim_d  = stim_q + N_IN'(1);
                    cnt_d   = '0;
                    state_d = StApply;
                end
            end

            // err_q already includes the last vector's compare here.
            StFinish: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            stim_q        <= '0;
            err_q         <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            pass_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stim_q        <= stim_d;
            err_q         <= err_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
            pass_q        <= pass_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign stim_out        = stim_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = first_valid_q;
    assign first_err_idx   = first_idx_q;

endmodule
